// File: rtl/relogio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | relogio_pkg : shared types and limits for the adjustable HH:MM:SS clock |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package relogio_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } modo_t;

    typedef struct packed {
        logic       en;
        logic [3:0] val;
        logic       dp_n;
    } digit_t;

    localparam logic [5:0] SEG_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HORA_MAX = 5'd23;
    localparam digit_t     DIG_OFF  = 6'b0;

    function automatic digit_t mk_digit(input logic en_i, input logic [3:0] val_i, input logic dp_n_i);
        digit_t d;
        d.en   = en_i;
        d.val  = val_i;
        d.dp_n = dp_n_i;
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bin_to_bcd : splits a 0..99 binary value into tens and units digits  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bin_to_bcd (
    input  logic [6:0] bin_i,
    output logic [3:0] tens_o,
    output logic [3:0] units_o
);

    assign tens_o  = 4'(bin_i / 7'd10);
    assign units_o = 4'(bin_i % 7'd10);

endmodule
`default_nettype wire

// File: rtl/relogio_ajustavel_btn.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | relogio_btn : 2-FF sync, optional debounce (RELOGIO_DEBOUNCE_EN),    |
// |               rising-edge one-cycle pulse. Rev 1.0                   |
// +----------------------------------------------------------------------+
module relogio_btn #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk_100MHz,
    input  logic rstn,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic w_level;

    always_ff @(posedge clk_100MHz or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= w_level;
        end
    end

`ifdef RELOGIO_DEBOUNCE_EN
    localparam int            CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic          stable_q;

    // A new level is accepted only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk_100MHz or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (sync2_q == stable_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            stable_q <= sync2_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign w_level = stable_q;
`else
    // A non-positive DEB_CYCLES disables the button entirely.
    localparam bit DEB_ACTIVE = (DEB_CYCLES > 0);

    assign w_level = sync2_q & DEB_ACTIVE;
`endif

    assign pulse_o = w_level & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/relogio_ajustavel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | relogio_ajustavel : settable HH:MM:SS clock driving eight digit words |
// |   optional debounce via RELOGIO_DEBOUNCE_EN. Rev 1.0                 |
// +----------------------------------------------------------------------+
module relogio_ajustavel
    import relogio_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int H24         = 1,
    parameter int DEB_CYCLES  = 1_000_000
) (
    input  logic       clk_100MHz,
    input  logic       rstn,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] d1,
    output logic [5:0] d2,
    output logic [5:0] d3,
    output logic [5:0] d4,
    output logic [5:0] d5,
    output logic [5:0] d6,
    output logic [5:0] d7,
    output logic [5:0] d8,
    output logic       tick_1hz,
    output logic [1:0] modo
);

    localparam int            PW       = $clog2(CLK_FREQ_HZ);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_FREQ_HZ - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(CLK_FREQ_HZ / 2);
    localparam logic [PW-1:0] BLK_LAST = PW'(CLK_FREQ_HZ / 4 - 1);
    localparam bit            IS_24H   = (H24 != 0);

    logic          mode_p, inc_p, w_tick, tick_q;
    modo_t         state_q;
    logic [PW-1:0] presc_q, presc_d, blk_q, blk_d;
    logic          blink_q, blink_d;
    logic [5:0]    sec_q, sec_d, min_q, min_d;
    logic [4:0]    hora_q, hora_d, w_hora_disp;
    logic          w_pm, w_sep_n, w_en_s, w_en_m, w_en_h;
    logic [3:0]    seg_t, seg_u, min_t, min_u, hora_t, hora_u;

    relogio_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_mode (
        .clk_100MHz(clk_100MHz), .rstn(rstn), .btn_i(btn_mode), .pulse_o(mode_p)
    );
    relogio_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_inc (
        .clk_100MHz(clk_100MHz), .rstn(rstn), .btn_i(btn_inc), .pulse_o(inc_p)
    );

    always_ff @(posedge clk_100MHz or negedge rstn) begin
        if (!rstn) begin
            state_q <= RUN;
        end else if (mode_p) begin
            case (state_q)
                RUN:     state_q <= SET_H;
                SET_H:   state_q <= SET_M;
                SET_M:   state_q <= SET_S;
                default: state_q <= RUN;
            endcase
        end
    end

    always_comb begin
        presc_d = '0;
        w_tick  = 1'b0;
        if (state_q == RUN) begin
            if (presc_q == PRE_LAST) w_tick = 1'b1;
            else                     presc_d = presc_q + 1'b1;
        end

        blk_d   = blk_q + 1'b1;
        blink_d = blink_q;
        if (mode_p) begin
            blk_d   = '0;
            blink_d = 1'b0;
        end else if (blk_q == BLK_LAST) begin
            blk_d   = '0;
            blink_d = ~blink_q;
        end

        sec_d  = sec_q;
        min_d  = min_q;
        hora_d = hora_q;
        // A tick can only occur in RUN, where increments are ignored anyway.
        if (w_tick) begin
            if (sec_q == SEG_MAX) begin
                sec_d = '0;
                if (min_q == MIN_MAX) begin
                    min_d  = '0;
                    hora_d = (hora_q == HORA_MAX) ? 5'd0 : hora_q + 1'b1;
                end else begin
                    min_d = min_q + 1'b1;
                end
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end else if (inc_p && !mode_p) begin
            case (state_q)
                SET_H:   hora_d = (hora_q == HORA_MAX) ? 5'd0 : hora_q + 1'b1;
                SET_M:   min_d  = (min_q == MIN_MAX) ? 6'd0 : min_q + 1'b1;
                SET_S:   sec_d  = '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or negedge rstn) begin
        if (!rstn) begin
            presc_q <= '0;
            blk_q   <= '0;
            blink_q <= 1'b0;
            sec_q   <= '0;
            min_q   <= '0;
            hora_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            blk_q   <= blk_d;
            blink_q <= blink_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hora_q  <= hora_d;
            tick_q  <= w_tick;
        end
    end

    always_comb begin
        w_pm = !IS_24H && (hora_q >= 5'd12);
        if (IS_24H)               w_hora_disp = hora_q;
        else if (hora_q == 5'd0)  w_hora_disp = 5'd12;
        else if (hora_q > 5'd12)  w_hora_disp = hora_q - 5'd12;
        else                      w_hora_disp = hora_q;
    end

    bin_to_bcd u_bcd_seg  (.bin_i({1'b0, sec_q}),        .tens_o(seg_t),  .units_o(seg_u));
    bin_to_bcd u_bcd_min  (.bin_i({1'b0, min_q}),        .tens_o(min_t),  .units_o(min_u));
    bin_to_bcd u_bcd_hora (.bin_i({2'b0, w_hora_disp}),  .tens_o(hora_t), .units_o(hora_u));

    assign w_sep_n = (state_q == RUN) ? (presc_q >= PRE_HALF) : 1'b0;
    assign w_en_s  = !((state_q == SET_S) && blink_q);
    assign w_en_m  = !((state_q == SET_M) && blink_q);
    assign w_en_h  = !((state_q == SET_H) && blink_q);

    always_ff @(posedge clk_100MHz or negedge rstn) begin
        if (!rstn) begin
            d1       <= mk_digit(1'b1, 4'd0, 1'b1);
            d2       <= mk_digit(1'b1, 4'd0, 1'b1);
            d3       <= mk_digit(1'b1, 4'd0, 1'b1);
            d4       <= mk_digit(1'b1, 4'd0, 1'b1);
            d5       <= mk_digit(1'b1, IS_24H ? 4'd0 : 4'd2, 1'b1);
            d6       <= mk_digit(1'b1, IS_24H ? 4'd0 : 4'd1, 1'b1);
            d7       <= DIG_OFF;
            d8       <= DIG_OFF;
            tick_1hz <= 1'b0;
            modo     <= RUN;
        end else begin
            d1       <= mk_digit(w_en_s, seg_u, 1'b1);
            d2       <= mk_digit(w_en_s, seg_t, 1'b1);
            d3       <= mk_digit(w_en_m, min_u, w_sep_n);
            d4       <= mk_digit(w_en_m, min_t, 1'b1);
            d5       <= mk_digit(w_en_h, hora_u, w_sep_n);
            d6       <= mk_digit(w_en_h, hora_t, ~w_pm);
            d7       <= DIG_OFF;
            d8       <= DIG_OFF;
            tick_1hz <= tick_q;
            modo     <= state_q;
        end
    end

endmodule
`default_nettype wire
